mont_final_sub: RTL and testbench

Limb-serial conditional subtractor that sits directly downstream of the pipelined 1030-bit carry-select adder in the Montgomery datapath. It takes the final Montgomery sum T (< 2M) and the 1029-bit modulus M, computes T − M one 64-bit limb per cycle, and returns T − M if no final borrow occurs, else T. It lets the core release the wide adder as soon as the last iteration completes.

---
 rtl/mont_final_sub_if.sv | 24 ++
 rtl/mont_final_sub.sv | 95 +++++++++
 tb/tb_mont_final_sub.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mont_final_sub_if.sv
// Request/response bundle between the Montgomery core and the final conditional subtractor.
// The core drives the master side; the subtractor takes the slave side.
interface mont_final_sub_if #(
    parameter int T_W = 1030,
    parameter int M_W = 1029
);
    logic           start;
    logic [T_W-1:0] in_t;
    logic [M_W-1:0] in_m;
    logic           busy;
    logic           done;
    logic [M_W-1:0] result;
    logic           subtracted;

    modport master (
        output start, in_t, in_m,
        input  busy, done, result, subtracted
    );

    modport slave (
        input  start, in_t, in_m,
        output busy, done, result, subtracted
    );
endinterface

// File: rtl/mont_final_sub.sv
// Limb-serial T - M with final-borrow select: returns T - M when T >= M, else T.
// Fixed latency of NLIMB+1 cycles from an accepted start to the done pulse.
module mont_final_sub #(
    parameter int NLIMB  = 17,
    parameter int LIMB_W = 64
) (
    input  logic           clk,
    input  logic           reset,
    mont_final_sub_if.slave bus
);
    localparam int T_W   = 1030;
    localparam int M_W   = 1029;
    localparam int W     = NLIMB * LIMB_W;
    localparam int CNT_W = (NLIMB > 1) ? $clog2(NLIMB) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SUB  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NLIMB - 1);

    logic [1:0]       r_state;
    logic [W-1:0]     r_t_sr;
    logic [W-1:0]     r_m_sr;
    logic [W-1:0]     r_diff_sr;
    logic [M_W-1:0]   r_t_hold;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;
    logic [M_W-1:0]   r_result;
    logic             r_subtracted;

    logic [LIMB_W:0]  w_sub;
    logic [LIMB_W-1:0] w_d;
    logic             w_b;
    logic [W-1:0]     w_diff_next;
    logic             w_unused;

    // One limb of T - M - borrow; the extra top bit is the outgoing borrow.
    assign w_sub = {1'b0, r_t_sr[LIMB_W-1:0]}
                 - {1'b0, r_m_sr[LIMB_W-1:0]}
                 - {{LIMB_W{1'b0}}, r_borrow};
    assign w_d   = w_sub[LIMB_W-1:0];
    assign w_b   = w_sub[LIMB_W];

    assign w_diff_next = {w_d, r_diff_sr[W-1:LIMB_W]};
    assign w_unused    = &{1'b0, r_diff_sr[LIMB_W-1:0], w_diff_next[W-1:M_W]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_t_sr       <= '0;
            r_m_sr       <= '0;
            r_diff_sr    <= '0;
            r_t_hold     <= '0;
            r_borrow     <= 1'b0;
            r_cnt        <= '0;
            r_result     <= '0;
            r_subtracted <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_t_sr   <= {{(W-T_W){1'b0}}, bus.in_t};
                        r_m_sr   <= {{(W-M_W){1'b0}}, bus.in_m};
                        r_t_hold <= bus.in_t[M_W-1:0];
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= S_SUB;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_SUB: begin
                    r_t_sr    <= r_t_sr >> LIMB_W;
                    r_m_sr    <= r_m_sr >> LIMB_W;
                    r_diff_sr <= w_diff_next;
                    r_borrow  <= w_b;
                    r_cnt     <= r_cnt + 1'b1;
                    // Result is committed on the edge into DONE so it is valid with the pulse.
                    if (r_cnt == LAST) begin
                        r_state      <= S_DONE;
                        r_result     <= w_b ? r_t_hold : w_diff_next[M_W-1:0];
                        r_subtracted <= ~w_b;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = (r_state == S_SUB);
    assign bus.done       = (r_state == S_DONE);
    assign bus.result     = r_result;
    assign bus.subtracted = r_subtracted;
endmodule

// File: tb/tb_mont_final_sub.sv
// Scoreboard bench for mont_final_sub: a whole-word reference model predicts each result
// and the cycle its done pulse must appear in.
module tb_mont_final_sub;
    localparam int NL = 17;
    localparam int LW = 64;
    localparam int CW = 1030;
    localparam int MW = 1029;
    localparam int LAT = NL + 1;

    typedef struct {
        logic [MW-1:0] res;
        logic          sub;
        int            dcyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    mont_final_sub_if bus ();

    mont_final_sub #(.NLIMB(NL), .LIMB_W(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] want);
        logic [CW-1:0] x, so, se;
        int k;
        total++;
        if (obs !== want) begin
            bad++;
            x = obs ^ want;
            k = 0;
            for (int i = CW - 1; i >= 0; i--) if (x[i] !== 1'b0) k = i;
            k = (k / 128) * 128;
            so = obs >> k;
            se = want >> k;
            $display("FAIL %s from_bit=%0d got=%h want=%h", tag, k, so[127:0], se[127:0]);
        end
    endtask

    function automatic exp_t model(input logic [CW-1:0] t, input logic [MW-1:0] m, input int dc);
        exp_t e;
        logic [CW:0] d;
        d = {1'b0, t} - {2'b00, m};
        if (!d[CW]) begin
            e.res = d[MW-1:0];
            e.sub = 1'b1;
        end else begin
            e.res = t[MW-1:0];
            e.sub = 1'b0;
        end
        e.dcyc = dc;
        return e;
    endfunction

    function automatic logic [CW-1:0] rnd();
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < 33; i++) r = (r << 32) | CW'($urandom);
        return r;
    endfunction

    // Output side of the scoreboard.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", CW'(bus.result), CW'(e.res));
                chk("subtracted", CW'(bus.subtracted), CW'(e.sub));
                chk("done_cycle", CW'(cyc), CW'(e.dcyc));
            end
        end
    end

    task automatic pulse(input logic [CW-1:0] t, input logic [MW-1:0] m, input bit push);
        logic [CW-1:0] r;
        bus.in_t  = t;
        bus.in_m  = m;
        bus.start = 1'b1;
        if (push) sb.push_back(model(t, m, cyc + LAT));
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_t  = rnd();
        r = rnd();
        bus.in_m  = r[MW-1:0];
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("timeout", CW'(sb.size()), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        logic [CW-1:0] t, r;
        logic [MW-1:0] m, m1;
        exp_t ea;
        int c0;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.in_t  = '0;
        bus.in_m  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", CW'(bus.busy), 0);
        chk("rst_done", CW'(bus.done), 0);
        chk("rst_result", CW'(bus.result), 0);
        chk("rst_sub", CW'(bus.subtracted), 0);
        reset = 1'b0;
        @(negedge clk);

        m1 = '0;
        m1[MW-1] = 1'b1;
        m1[1:0]  = 2'b11;

        // T = M + 5 with busy/done timing walk.
        c0 = cyc;
        pulse(CW'(m1) + CW'(5), m1, 1'b1);
        for (int i = 1; i <= LAT; i++) begin
            chk("busy_walk", CW'(bus.busy), CW'(i <= NL));
            chk("done_walk", CW'(bus.done), CW'(i == LAT));
            if (i < LAT) @(negedge clk);
        end
        wait_idle();

        pulse(CW'(m1) - CW'(1), m1, 1'b1);
        wait_idle();

        m = '0;
        m[MW-1] = 1'b1;
        m[0] = 1'b1;
        pulse(CW'(m), m, 1'b1);
        wait_idle();

        t = '0;
        t[MW-1] = 1'b1;
        pulse(t, MW'(1), 1'b1);
        wait_idle();

        // Random operands, including T >= 2M.
        for (int i = 0; i < 4; i++) begin
            r = rnd();
            m = r[MW-1:0];
            m[MW-1] = 1'b1;
            t = rnd();
            if (i == 0) t = CW'(m) - CW'(1);
            if (i == 1) t[CW-1] = 1'b0;
            pulse(t, m, 1'b1);
            wait_idle();
        end

        // Starts during SUB must be ignored.
        c0 = cyc;
        pulse(CW'(m1) + CW'(77), m1, 1'b1);
        while (cyc < c0 + 5) @(negedge clk);
        pulse(CW'(12345), MW'(3), 1'b0);
        while (cyc < c0 + 10) @(negedge clk);
        pulse(CW'(999), MW'(1000), 1'b0);
        wait_idle();

        // Abort with reset in cycle 9, restart in cycle 12.
        c0 = cyc;
        pulse(CW'(m1) + CW'(9), m1, 1'b1);
        while (cyc < c0 + 9) @(negedge clk);
        reset = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", CW'(bus.busy), 0);
        chk("abort_done", CW'(bus.done), 0);
        chk("abort_result", CW'(bus.result), 0);
        chk("abort_sub", CW'(bus.subtracted), 0);
        while (cyc < c0 + 12) @(negedge clk);
        pulse(CW'(m1) + CW'(33), m1, 1'b1);
        chk("restart_dcyc", CW'(sb[0].dcyc), CW'(c0 + 30));
        wait_idle();

        // Back-to-back: second start in the DONE cycle, first result held meanwhile.
        c0 = cyc;
        ea = model(CW'(m1) + CW'(1), m1, 0);
        pulse(CW'(m1) + CW'(1), m1, 1'b1);
        while (cyc < c0 + LAT) @(negedge clk);
        chk("b2b_done_a", CW'(bus.done), 1);
        t = '0;
        t[MW-2] = 1'b1;
        pulse(t, MW'(7), 1'b1);
        while (cyc < c0 + 2 * LAT) begin
            chk("b2b_hold", CW'(bus.result), CW'(ea.res));
            @(negedge clk);
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
